// File: rtl/apb_master_arb2_pkg.sv
// Shared types and defaults for the two-requester APB master.
// Holds the FSM state encoding, bus width defaults and the requester index type.
package apb_master_arb2_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Requester index: 0 = R0, 1 = R1.
  typedef logic req_idx_t;

  function automatic logic [1:0] idx_to_onehot(input req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/apb_master_arb2_if.sv
// APB bus bundle between the master and its peripherals.
// Handshake: a transfer completes in the ACCESS cycle (psel=1, penable=1) in which pready=1.
interface apb_master_arb2_if
  import apb_master_arb2_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic              psel;
  logic              penable;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  modport master (
    output paddr, pwrite, psel, penable, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata,
    output prdata, pready
  );

endinterface

// File: rtl/apb_master_arb2_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
// The last-grant register only moves when update_i is asserted with a live request.
module apb_master_arb2_rr_arb2
  import apb_master_arb2_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  req_idx_t last_q;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = idx_to_onehot(~last_q);
      default: gnt_o = 2'b00;
    endcase
  end

  // Reset to R1 so that the first tie after reset goes to R0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (update_i && (|req_i)) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/apb_master_arb2.sv
// Two-requester APB master: round-robin arbitration, IDLE->SETUP->ACCESS sequencing,
// pready wait states and timeout abort of hung slaves. All outputs registered.
module apb_master_arb2
  import apb_master_arb2_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              r0_valid,
  input  logic              r0_write,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_done,
  output logic              r0_err,
  input  logic              r1_valid,
  input  logic              r1_write,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_done,
  output logic              r1_err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output state_e            dbg_state_o,
  apb_master_arb2_if.master apb
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e            state_q;
  req_idx_t          grant_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              psel_q;
  logic              penable_q;
  logic              busy_q;
  logic [DATA_W-1:0] rdata_q;
  logic              r0_done_q, r1_done_q;
  logic              r0_err_q, r1_err_q;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       arb_update;

  assign req        = {r1_valid, r0_valid};
  assign arb_update = (state_q == IDLE);

  apb_master_arb2_rr_arb2 u_arb (
    .clk_i    (pclk),
    .rst_i    (rst),
    .req_i    (req),
    .update_i (arb_update),
    .gnt_o    (gnt)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
      r0_done_q <= 1'b0;
      r1_done_q <= 1'b0;
      r0_err_q  <= 1'b0;
      r1_err_q  <= 1'b0;
    end else begin
      r0_done_q <= 1'b0;
      r1_done_q <= 1'b0;
      r0_err_q  <= 1'b0;
      r1_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // Requester fields are captured only here; later changes are ignored.
          if (|gnt) begin
            grant_q   <= gnt[1];
            paddr_q   <= gnt[1] ? r1_addr  : r0_addr;
            pwrite_q  <= gnt[1] ? r1_write : r0_write;
            pwdata_q  <= gnt[1] ? r1_wdata : r0_wdata;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (apb.pready) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            busy_q    <= 1'b0;
            rdata_q   <= pwrite_q ? '0 : apb.prdata;
            r0_done_q <= ~grant_q;
            r1_done_q <= grant_q;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            busy_q    <= 1'b0;
            rdata_q   <= '0;
            r0_done_q <= ~grant_q;
            r1_done_q <= grant_q;
            r0_err_q  <= ~grant_q;
            r1_err_q  <= grant_q;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign apb.paddr   = paddr_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;

  assign r0_done     = r0_done_q;
  assign r1_done     = r1_done_q;
  assign r0_err      = r0_err_q;
  assign r1_err      = r1_err_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_master_arb2.sv
// Directed bench for apb_master_arb2 with an APB slave model (16x8 memory, programmable waits).
module tb_apb_master_arb2;
  import apb_master_arb2_pkg::*;

  logic       pclk;
  logic       rst;
  logic       r0_valid, r0_write, r1_valid, r1_write;
  logic [3:0] r0_addr, r1_addr;
  logic [7:0] r0_wdata, r1_wdata;
  logic       r0_done, r0_err, r1_done, r1_err;
  logic [7:0] rdata;
  logic       busy;
  state_e     dbg_state;

  int checks   = 0;
  int failures = 0;

  apb_master_arb2_if #(.ADDR_W(4), .DATA_W(8)) apb ();

  apb_master_arb2 #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(15)) dut (
    .pclk        (pclk),
    .rst         (rst),
    .r0_valid    (r0_valid),
    .r0_write    (r0_write),
    .r0_addr     (r0_addr),
    .r0_wdata    (r0_wdata),
    .r0_done     (r0_done),
    .r0_err      (r0_err),
    .r1_valid    (r1_valid),
    .r1_write    (r1_write),
    .r1_addr     (r1_addr),
    .r1_wdata    (r1_wdata),
    .r1_done     (r1_done),
    .r1_err      (r1_err),
    .rdata       (rdata),
    .busy        (busy),
    .dbg_state_o (dbg_state),
    .apb         (apb.master)
  );

  // ---------------- clock ----------------
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // ---------------- APB slave model ----------------
  logic [7:0] mem [16];
  int         wait_w = 0;
  int         wcnt   = 0;

  assign apb.pready = apb.psel && apb.penable && (wcnt == wait_w);
  assign apb.prdata = mem[apb.paddr];

  always @(posedge pclk) begin
    if (rst) begin
      wcnt <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if (apb.psel && apb.penable) begin
      if (apb.pready) begin
        if (apb.pwrite) mem[apb.paddr] <= apb.pwdata;
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Runs until a done pulse (bounded), counting edges and ACCESS cycles and
  // tracking paddr stability while psel is high.
  task automatic wait_done(input logic [3:0] exp_addr, output int edges, output int acc,
                           output logic d0, output logic d1, output logic e0, output logic e1,
                           output logic [7:0] rd, output logic addr_ok, output logic psel_after);
    logic seen;
    edges = 0; acc = 0; d0 = 0; d1 = 0; e0 = 0; e1 = 0; rd = 0;
    addr_ok = 1'b1; psel_after = 1'b1; seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      edges++;
      if (apb.psel && apb.penable) acc++;
      if (apb.psel && (apb.paddr !== exp_addr)) addr_ok = 1'b0;
      if (r0_done || r1_done) begin
        d0 = r0_done; d1 = r1_done; e0 = r0_err; e1 = r1_err;
        rd = rdata; psel_after = apb.psel; seen = 1'b1;
        break;
      end
    end
    check("done_seen_within_budget", 32'(seen), 32'd1);
    check("no_double_done", 32'(d0 && d1), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int         edges, acc;
  logic       d0, d1, e0, e1, addr_ok, psel_after;
  logic [7:0] rd;
  logic [1:0] grant_seq [4];

  initial begin
    #200000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    r0_valid = 0; r0_write = 0; r0_addr = 0; r0_wdata = 0;
    r1_valid = 0; r1_write = 0; r1_addr = 0; r1_wdata = 0;
    repeat (3) tick();

    // Reset state
    check("rst_psel",    32'(apb.psel),    32'd0);
    check("rst_penable", 32'(apb.penable), 32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_done",    32'({r0_done, r1_done, r0_err, r1_err}), 32'd0);
    check("rst_paddr",   32'(apb.paddr),   32'd0);
    check("rst_rdata",   32'(rdata),       32'd0);
    check("rst_state",   32'(dbg_state),   32'(IDLE));
    rst = 1'b0;
    tick();

    // R0 write addr 3 = 0xA5, zero waits
    wait_w = 0;
    r0_valid = 1; r0_write = 1; r0_addr = 4'd3; r0_wdata = 8'hA5;
    tick();
    check("wr_setup_psel",    32'(apb.psel),    32'd1);
    check("wr_setup_penable", 32'(apb.penable), 32'd0);
    check("wr_setup_paddr",   32'(apb.paddr),   32'd3);
    check("wr_setup_pwdata",  32'(apb.pwdata),  32'hA5);
    check("wr_setup_busy",    32'(busy),        32'd1);
    tick();
    check("wr_access_penable", 32'(apb.penable), 32'd1);
    tick();
    check("wr_done_3_edges", 32'(r0_done), 32'd1);
    check("wr_err",          32'(r0_err),  32'd0);
    check("wr_psel_off",     32'(apb.psel), 32'd0);
    check("wr_busy_off",     32'(busy),    32'd0);
    r0_valid = 0;
    tick();
    check("wr_done_one_cycle", 32'(r0_done), 32'd0);
    check("wr_mem3", 32'(mem[3]), 32'hA5);

    // R1 read addr 3, two wait states
    wait_w = 2;
    r1_valid = 1; r1_write = 0; r1_addr = 4'd3;
    wait_done(4'd3, edges, acc, d0, d1, e0, e1, rd, addr_ok, psel_after);
    r1_valid = 0;
    check("rd_edges",    32'(edges),  32'd5);
    check("rd_access3",  32'(acc),    32'd3);
    check("rd_r1_done",  32'({d0, d1}), 32'b01);
    check("rd_r1_err",   32'(e1),     32'd0);
    check("rd_rdata",    32'(rd),     32'hA5);
    check("rd_addr_stable", 32'(addr_ok), 32'd1);

    // Tie held by both: R0 writes addr 1, R1 reads addr 3; grants alternate
    wait_w = 0;
    r0_valid = 1; r0_write = 1; r0_addr = 4'd1; r0_wdata = 8'h11;
    r1_valid = 1; r1_write = 0; r1_addr = 4'd3;
    for (int k = 0; k < 4; k++) begin
      wait_done((k % 2 == 0) ? 4'd1 : 4'd3, edges, acc, d0, d1, e0, e1, rd, addr_ok, psel_after);
      grant_seq[k] = {d1, d0};
      check("alt_edges", 32'(edges), 32'd3);
      if (k % 2 == 1) check("alt_r1_rdata", 32'(rd), 32'hA5);
    end
    r0_valid = 0; r1_valid = 0;
    check("alt_grant0", 32'(grant_seq[0]), 32'b01);
    check("alt_grant1", 32'(grant_seq[1]), 32'b10);
    check("alt_grant2", 32'(grant_seq[2]), 32'b01);
    check("alt_grant3", 32'(grant_seq[3]), 32'b10);
    tick();
    check("alt_mem1", 32'(mem[1]), 32'h11);

    // Timeout: 20 waits against TIMEOUT=15
    wait_w = 20;
    r0_valid = 1; r0_write = 1; r0_addr = 4'd5; r0_wdata = 8'h5A;
    wait_done(4'd5, edges, acc, d0, d1, e0, e1, rd, addr_ok, psel_after);
    r0_valid = 0;
    check("to_edges",   32'(edges),      32'd17);
    check("to_access",  32'(acc),        32'd15);
    check("to_done",    32'({d0, d1}),   32'b10);
    check("to_err",     32'(e0),         32'd1);
    check("to_rdata",   32'(rd),         32'd0);
    check("to_psel",    32'(psel_after), 32'd0);
    check("to_no_write", 32'(mem[5]),    32'd0);
    tick();

    // Reset during ACCESS of an R0 read
    wait_w = 20;
    r0_valid = 1; r0_write = 0; r0_addr = 4'd4;
    tick();
    tick();
    check("mid_in_access", 32'(dbg_state), 32'(ACCESS));
    rst = 1'b1; r0_valid = 0;
    tick();
    check("mid_rst_psel",    32'(apb.psel),    32'd0);
    check("mid_rst_penable", 32'(apb.penable), 32'd0);
    check("mid_rst_busy",    32'(busy),        32'd0);
    check("mid_rst_nodone",  32'({r0_done, r1_done}), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_nodone", 32'({r0_done, r1_done, apb.psel}), 32'd0);
    end

    // Post-reset tie goes to R0; R0 changes addr 3->7 mid-ACCESS
    wait_w = 3;
    r0_valid = 1; r0_write = 1; r0_addr = 4'd3; r0_wdata = 8'h3C;
    r1_valid = 1; r1_write = 0; r1_addr = 4'd3;
    tick();
    check("tie_r0_pwrite", 32'(apb.pwrite), 32'd1);
    check("tie_r0_pwdata", 32'(apb.pwdata), 32'h3C);
    tick();
    r0_addr = 4'd7; r0_wdata = 8'hFF;
    wait_done(4'd3, edges, acc, d0, d1, e0, e1, rd, addr_ok, psel_after);
    r0_valid = 0;
    check("tie_r0_first",   32'({d0, d1}), 32'b10);
    check("chg_addr_stable", 32'(addr_ok), 32'd1);
    wait_done(4'd3, edges, acc, d0, d1, e0, e1, rd, addr_ok, psel_after);
    r1_valid = 0;
    check("chg_r1_done",  32'({d0, d1}), 32'b01);
    check("chg_r1_rdata", 32'(rd), 32'h3C);
    check("chg_mem7",     32'(mem[7]), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
